// File: rtl/instr_fetch_uni_pkg.sv
// Shared definitions for the instruction-fetch front end and the
// single-cycle control/datapath behind it.
//   - RV32I opcode / funct3 field constants used by the decoder
//   - PC-origin codes driven by the datapath to select the next PC
//   - fetch sequencer state encoding
//   - canonical NOP (addi x0, x0, 0) shown before the first fetch
package instr_fetch_uni_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  // Branch funct3 (instr[14:12]) for OPC_BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // PC-origin code supplied by the datapath with each retired instruction
  localparam logic [1:0] ORIGPC_SEQ    = 2'b00;
  localparam logic [1:0] ORIGPC_BRANCH = 2'b01;
  localparam logic [1:0] ORIGPC_JAL    = 2'b10;
  localparam logic [1:0] ORIGPC_JALR   = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_RST   = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_TRAP  = 2'b11
  } fetch_state_e;

  // Instruction addresses must be word aligned (no compressed ISA)
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_uni_if.sv
// Bus bundle between the fetch unit, the instruction memory and the
// datapath/decoder.
//   master : fetch unit (drives memory request and decoder-side outputs)
//   slave  : environment (instruction memory + datapath)
// Memory side   : oIMemReq, oIMemAddr -> ; <- iIMemAck, iIMemRData
// Decoder side  : oInstr, oPC, oPCPlus4, oInstrValid ->
// Datapath side : <- iAdvance, iOrigPC, iTaken, iTarget
// Status        : oTrap, oTrapPC, oInstrCount ->
interface instr_fetch_uni_if #(
  parameter int XLEN = 32
);
  logic            oIMemReq;
  logic [XLEN-1:0] oIMemAddr;
  logic            iIMemAck;
  logic [XLEN-1:0] iIMemRData;

  logic [XLEN-1:0] oInstr;
  logic [XLEN-1:0] oPC;
  logic [XLEN-1:0] oPCPlus4;
  logic            oInstrValid;

  logic            iAdvance;
  logic [1:0]      iOrigPC;
  logic            iTaken;
  logic [XLEN-1:0] iTarget;

  logic            oTrap;
  logic [XLEN-1:0] oTrapPC;
  logic [XLEN-1:0] oInstrCount;

  modport master (
    output oIMemReq, oIMemAddr,
    input  iIMemAck, iIMemRData,
    output oInstr, oPC, oPCPlus4, oInstrValid,
    input  iAdvance, iOrigPC, iTaken, iTarget,
    output oTrap, oTrapPC, oInstrCount
  );

  modport slave (
    input  oIMemReq, oIMemAddr,
    output iIMemAck, iIMemRData,
    input  oInstr, oPC, oPCPlus4, oInstrValid,
    output iAdvance, iOrigPC, iTaken, iTarget,
    input  oTrap, oTrapPC, oInstrCount
  );
endinterface

// File: rtl/instr_fetch_uni_nextpc.sv
// Next-PC selection, purely combinational.
//   pc_i         current PC
//   orig_pc_i    PC-origin code (seq / branch / JAL / JALR)
//   taken_i      branch outcome, only meaningful for ORIGPC_BRANCH
//   target_i     datapath-computed target
//   next_pc_o    selected next PC (PC+4 wraps modulo 2^32)
//   misaligned_o next_pc_o is not word aligned
module instr_fetch_uni_nextpc
  import instr_fetch_uni_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  orig_pc_i,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] seq_pc;

  assign seq_pc = pc_i + 32'd4;

  always_comb begin
    next_pc_o = seq_pc;
    unique case (orig_pc_i)
      ORIGPC_SEQ:    next_pc_o = seq_pc;
      ORIGPC_BRANCH: next_pc_o = taken_i ? target_i : seq_pc;
      ORIGPC_JAL:    next_pc_o = target_i;
      // JALR clears bit 0 before the alignment check, so only bit 1 can trap
      ORIGPC_JALR:   next_pc_o = {target_i[31:1], 1'b0};
      default:       next_pc_o = seq_pc;
    endcase
  end

  assign misaligned_o = !is_word_aligned(next_pc_o);

endmodule

// File: rtl/instr_fetch_uni.sv
// PC register and instruction-fetch sequencer for the single-cycle core.
// Requests one word per instruction from instruction memory, holds the
// fetched word and its PC stable while the datapath executes it, then
// steps the PC from the PC-origin code once the datapath signals
// completion. Retired instructions are counted; a misaligned next PC
// parks the unit in a sticky trap until reset.
//   iCLK  clock (rising edge)
//   iRST  asynchronous active-high reset
//   bus   instr_fetch_uni_if.master: memory request/ack, decoder outputs,
//         datapath completion/target inputs, trap and retire counter
module instr_fetch_uni
  import instr_fetch_uni_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
)(
  input  logic                iCLK,
  input  logic                iRST,
  instr_fetch_uni_if.master   bus
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            req_q;
  logic            valid_q;
  logic            trap_q;
  logic [XLEN-1:0] trap_pc_q;
  logic [XLEN-1:0] count_q;

  logic [XLEN-1:0] next_pc_d;
  logic            misaligned_d;

  instr_fetch_uni_nextpc u_nextpc (
    .pc_i         (pc_q),
    .orig_pc_i    (bus.iOrigPC),
    .taken_i      (bus.iTaken),
    .target_i     (bus.iTarget),
    .next_pc_o    (next_pc_d),
    .misaligned_o (misaligned_d)
  );

  // Request/valid are registered alongside the state so every output
  // changes only on a clock edge (or asynchronously on reset).
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_RST;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
      count_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end

        ST_FETCH: begin
          if (bus.iIMemAck) begin
            instr_q <= bus.iIMemRData;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (bus.iAdvance) begin
            // The trapping instruction still retires; PC keeps its value.
            count_q <= count_q + 1'b1;
            valid_q <= 1'b0;
            if (misaligned_d) begin
              trap_q    <= 1'b1;
              trap_pc_q <= next_pc_d;
              state_q   <= ST_TRAP;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end

        ST_TRAP: begin
          state_q <= ST_TRAP;
        end

        default: begin
          state_q <= ST_RST;
        end
      endcase
    end
  end

  assign bus.oIMemReq    = req_q;
  assign bus.oIMemAddr   = pc_q;
  assign bus.oInstr      = instr_q;
  assign bus.oPC         = pc_q;
  assign bus.oPCPlus4    = pc_q + 32'd4;
  assign bus.oInstrValid = valid_q;
  assign bus.oTrap       = trap_q;
  assign bus.oTrapPC     = trap_pc_q;
  assign bus.oInstrCount = count_q;

endmodule

// File: tb/tb_instr_fetch_uni.sv
// Bench for instr_fetch_uni: memory/datapath driver plus a scoreboard
// monitor checking fetch addresses and presented instructions.
module tb_instr_fetch_uni;
  import instr_fetch_uni_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_uni_if #(.XLEN(32)) bus ();

  instr_fetch_uni #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_instr_q[$];   // {pc, word}
  logic [31:0] m_pc;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not matched by any expectation", name);
  endtask

  // Architectural next-PC rule
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] orig,
                                             input logic taken, input logic [31:0] tgt);
    logic [31:0] seq;
    seq = pc + 32'd4;
    case (orig)
      2'd0: return seq;
      2'd1: return taken ? tgt : seq;
      2'd2: return tgt;
      default: return tgt & 32'hFFFF_FFFE;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic req_prev   = 1'b0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      req_prev   = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (bus.oIMemReq && !req_prev) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_req");
        else check("fetch_addr", bus.oIMemAddr, exp_addr_q.pop_front());
      end
      if (bus.oInstrValid && !valid_prev) begin
        if (exp_instr_q.size() == 0) fail_now("unexpected_valid");
        else begin
          logic [63:0] e;
          e = exp_instr_q.pop_front();
          check("instr", bus.oInstr, e[31:0]);
          check("pc", bus.oPC, e[63:32]);
          check("pc_plus4", bus.oPCPlus4, e[63:32] + 32'd4);
        end
      end
      req_prev   = bus.oIMemReq;
      valid_prev = bus.oInstrValid;
    end
  end

  // ---------------- driver tasks (entered/left on a negedge) ----------------
  task automatic do_reset(input bit stale_ack);
    #2 rst = 1'b1;
    #1;
    check("rst_req", {31'b0, bus.oIMemReq}, 32'd0);
    check("rst_valid", {31'b0, bus.oInstrValid}, 32'd0);
    check("rst_instr", bus.oInstr, NOP_INSTR);
    check("rst_trap", {31'b0, bus.oTrap}, 32'd0);
    check("rst_trappc", bus.oTrapPC, 32'd0);
    check("rst_count", bus.oInstrCount, 32'd0);
    check("rst_pc", bus.oPC, RST_PC);
    m_pc    = RST_PC;
    m_count = 0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(RST_PC);
    bus.iIMemAck = 1'b0;
    bus.iAdvance = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (stale_ack) begin
      // late ack from the abandoned request, seen by the first edge after release
      bus.iIMemAck   = 1'b1;
      bus.iIMemRData = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.iIMemAck = 1'b0;
    check("post_rst_valid", {31'b0, bus.oInstrValid}, 32'd0);
  endtask

  task automatic fetch(input int waits, input logic [31:0] word, input bit stray_ack);
    int n;
    logic [31:0] a;
    n = 0;
    while (!bus.oIMemReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.oIMemReq) begin
      fail_now("req_timeout");
      return;
    end
    a = bus.oIMemAddr;
    for (int i = 0; i < waits; i++) begin
      bus.iIMemAck   = 1'b0;
      bus.iIMemRData = $urandom;
      bus.iAdvance   = 1'($urandom);    // ignored outside ISSUE
      @(negedge clk);
      check("req_held", {31'b0, bus.oIMemReq}, 32'd1);
      check("addr_held", bus.oIMemAddr, a);
      check("valid_low_wait", {31'b0, bus.oInstrValid}, 32'd0);
    end
    bus.iIMemAck   = 1'b1;
    bus.iIMemRData = word;
    exp_instr_q.push_back({m_pc, word});
    @(negedge clk);
    bus.iIMemAck   = 1'b0;
    bus.iIMemRData = $urandom;
    bus.iAdvance   = 1'b0;
    check("valid_after_ack", {31'b0, bus.oInstrValid}, 32'd1);
    check("req_drop", {31'b0, bus.oIMemReq}, 32'd0);
    if (stray_ack) begin
      bus.iIMemAck = 1'b1;
      @(negedge clk);
      bus.iIMemAck = 1'b0;
      check("instr_hold", bus.oInstr, word);
      check("valid_hold", {31'b0, bus.oInstrValid}, 32'd1);
    end
  endtask

  task automatic advance(input int delay, input logic [1:0] orig, input logic taken,
                         input logic [31:0] tgt, output bit trapped);
    logic [31:0] np;
    for (int i = 0; i < delay; i++) begin
      bus.iAdvance = 1'b0;
      bus.iOrigPC  = 2'($urandom);
      bus.iTaken   = 1'($urandom);
      bus.iTarget  = $urandom;
      @(negedge clk);
    end
    bus.iAdvance = 1'b1;
    bus.iOrigPC  = orig;
    bus.iTaken   = taken;
    bus.iTarget  = tgt;
    np      = model_next(m_pc, orig, taken, tgt);
    m_count = m_count + 1;
    trapped = (np[1:0] != 2'b00);
    if (!trapped) begin
      m_pc = np;
      exp_addr_q.push_back(np);
    end
    @(negedge clk);
    bus.iAdvance = 1'b0;
    bus.iTarget  = $urandom;
    check("count", bus.oInstrCount, m_count);
    check("valid_drop", {31'b0, bus.oInstrValid}, 32'd0);
    check("trap_flag", {31'b0, bus.oTrap}, {31'b0, trapped});
    if (trapped) begin
      check("trap_pc", bus.oTrapPC, np);
      for (int i = 0; i < 6; i++) begin
        bus.iIMemAck = 1'($urandom);
        bus.iAdvance = 1'($urandom);
        @(negedge clk);
        check("trap_sticky", {31'b0, bus.oTrap}, 32'd1);
        check("trap_no_req", {31'b0, bus.oIMemReq}, 32'd0);
        check("trap_count", bus.oInstrCount, m_count);
      end
      bus.iIMemAck = 1'b0;
      bus.iAdvance = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit t;
    bus.iIMemAck   = 1'b0;
    bus.iIMemRData = '0;
    bus.iAdvance   = 1'b0;
    bus.iOrigPC    = '0;
    bus.iTaken     = 1'b0;
    bus.iTarget    = '0;
    m_pc    = RST_PC;
    m_count = 0;
    @(negedge clk);
    do_reset(1'b0);

    // zero-wait first fetch, then walk PC up to 0x0040_0010
    fetch(0, 32'h0050_0093, 1'b0); advance(0, ORIGPC_SEQ, 1'b0, 32'h0, t);
    fetch(3, 32'h1111_1111, 1'b1); advance(1, ORIGPC_SEQ, 1'b0, 32'h0, t);
    fetch(0, 32'h2222_2222, 1'b0); advance(0, ORIGPC_SEQ, 1'b0, 32'h0, t);
    fetch(1, 32'h3333_3333, 1'b0); advance(2, ORIGPC_SEQ, 1'b0, 32'h0, t);
    // PC = 0x0040_0010
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_BRANCH, 1'b0, 32'h0040_0100, t);
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_JAL,    1'b0, 32'h0040_0010, t);
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_BRANCH, 1'b1, 32'h0040_0100, t);
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_JAL,    1'b0, 32'h0040_0010, t);
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_JALR,   1'b0, 32'h0040_0201, t);
    // PC+4 wrap
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_JAL,    1'b0, 32'hFFFF_FFFC, t);
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_SEQ,    1'b0, 32'h0, t);
    // misaligned JAL target traps
    fetch(0, $urandom, 1'b0); advance(0, ORIGPC_JAL,    1'b0, 32'h0040_0102, t);
    check("directed_trap", {31'b0, t}, 32'd1);

    // reset mid-fetch with a late ack right after release
    do_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    do_reset(1'b1);
    fetch(0, 32'h0050_0093, 1'b0); advance(0, ORIGPC_SEQ, 1'b0, 32'h0, t);

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9, 0) == 0) tgt = tgt | 32'($urandom_range(3, 1));
      fetch($urandom_range(3, 0), $urandom, ($urandom_range(3, 0) == 0));
      advance($urandom_range(2, 0), 2'($urandom), 1'($urandom), tgt, t);
      if (t) do_reset(1'($urandom));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
